// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time from
// instruction memory and hands it to the decoder, then waits for the commit.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,

    output logic        ifu_valid,
    input  logic        idu_ready,
    output logic [31:0] real_ins,
    output logic [31:0] pc,
    output logic        fetch_err,

    input  logic        commit_valid,
    input  logic        commit_redirect,
    input  logic [31:0] commit_target,

    output logic [31:0] fetch_cnt
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_EXEC  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ins_q, ins_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; events that arrive in the wrong state fall through to the hold defaults
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    ins_d   = imem_rsp_err ? '0 : imem_rsp_data;
                    err_d   = imem_rsp_err;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (idu_ready) begin
                    cnt_d   = cnt_q + XLEN'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (commit_valid) begin
                    pc_d    = commit_redirect ? {commit_target[XLEN-1:2], 2'b00}
                                              : pc_q + XLEN'(4);
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Handshake outputs decode registered state only
    assign imem_req_valid = (state_q == S_REQ);
    assign ifu_valid      = (state_q == S_VALID);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign real_ins       = ins_q;
    assign fetch_err      = err_q;
    assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu.sv
// Randomized scoreboard bench for ifu: the driver pushes the expected handover
// when it returns a memory response; a monitor pops on every decoder handshake.
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        ifu_valid;
    logic        idu_ready;
    logic [31:0] real_ins;
    logic [31:0] pc;
    logic        fetch_err;
    logic        commit_valid;
    logic        commit_redirect;
    logic [31:0] commit_target;
    logic [31:0] fetch_cnt;

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .imem_rsp_err    (imem_rsp_err),
        .ifu_valid       (ifu_valid),
        .idu_ready       (idu_ready),
        .real_ins        (real_ins),
        .pc              (pc),
        .fetch_err       (fetch_err),
        .commit_valid    (commit_valid),
        .commit_redirect (commit_redirect),
        .commit_target   (commit_target),
        .fetch_cnt       (fetch_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the handshake completes on the coming rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ifu_valid && idu_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_handover", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ho_pc", pc, e.pc);
                    chk("ho_real_ins", real_ins, e.ins);
                    chk("ho_fetch_err", 32'(fetch_err), 32'(e.err));
                    chk("ho_fetch_cnt", fetch_cnt, e.cnt);
                end
            end
        end
    end

    // One complete instruction; called with the DUT in its request state at a falling edge
    task automatic do_fetch(input int acc, input int lat, input logic [31:0] data,
                            input logic err, input int stall, input int clat,
                            input logic redir, input logic [31:0] tgt,
                            input logic sp_c, input logic sp_r);
        exp_t e;
        for (int i = 0; i <= acc; i++) begin
            chk("req_valid", 32'(imem_req_valid), 32'd1);
            chk("imem_addr", imem_addr, model_pc);
            imem_req_ready = (i == acc);
            @(negedge clk);
        end
        imem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk("wait_no_valid", 32'(ifu_valid), 32'd0);
            commit_valid    = sp_c;
            commit_redirect = sp_c;
            commit_target   = 32'h1234_5670;
            @(negedge clk);
        end
        commit_valid    = 1'b0;
        commit_redirect = 1'b0;
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = data;
        imem_rsp_err    = err;
        e.pc  = model_pc;
        e.ins = err ? 32'd0 : data;
        e.err = err;
        e.cnt = model_cnt;
        sb_q.push_back(e);
        model_cnt = model_cnt + 32'd1;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(ifu_valid), 32'd1);
            chk("stall_ins", real_ins, e.ins);
            chk("stall_pc", pc, e.pc);
            chk("stall_err", 32'(fetch_err), 32'(e.err));
            commit_valid = sp_c;
            @(negedge clk);
        end
        chk("valid_at_hs", 32'(ifu_valid), 32'd1);
        commit_valid = sp_c;
        idu_ready    = 1'b1;
        @(negedge clk);
        idu_ready    = 1'b0;
        commit_valid = 1'b0;
        chk("exec_no_valid", 32'(ifu_valid), 32'd0);
        chk("exec_fetch_cnt", fetch_cnt, model_cnt);
        for (int i = 0; i < clat; i++) begin
            imem_rsp_valid = sp_r;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = sp_r;
            @(negedge clk);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        chk("exec_ins_held", real_ins, e.ins);
        chk("exec_pc_held", pc, e.pc);
        commit_valid    = 1'b1;
        commit_redirect = redir;
        commit_target   = tgt;
        @(negedge clk);
        commit_valid    = 1'b0;
        commit_redirect = 1'b0;
        model_pc = redir ? (tgt & 32'hFFFF_FFFC) : model_pc + 32'd4;
        chk("err_cleared", 32'(fetch_err), 32'd0);
        chk("pc_after_commit", pc, model_pc);
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        imem_rsp_err = 1'b0;
        idu_ready = 1'b0;
        commit_valid = 1'b0;
        commit_redirect = 1'b0;
        commit_target = '0;
        model_pc = RST_PC;
        model_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_ifu_valid", 32'(ifu_valid), 32'd0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_real_ins", real_ins, 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        rst = 1'b0;

        // First fetch, decoder stall, redirect, spurious events, fault
        do_fetch(0, 1, 32'h0000_0093, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("first_cnt", fetch_cnt, 32'd1);
        chk("second_addr", imem_addr, 32'h8000_0004);
        do_fetch(0, 1, 32'h0010_0113, 1'b0, 5, 0, 1'b1, 32'h8000_0103, 1'b0, 1'b0);
        chk("redirect_addr", imem_addr, 32'h8000_0100);
        do_fetch(1, 3, 32'h0020_8193, 1'b0, 2, 3, 1'b0, 32'd0, 1'b1, 1'b1);
        do_fetch(0, 2, 32'hDEAD_BEEF, 1'b1, 1, 1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("fault_cleared", 32'(fetch_err), 32'd0);

        // PC wrap
        do_fetch(0, 1, 32'h0000_0013, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        chk("pre_wrap_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(0, 1, 32'h0000_0013, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        for (int n = 0; n < 150; n++) begin
            do_fetch($urandom_range(0, 2), $urandom_range(1, 3), $urandom,
                     ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                     $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for memory
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ifu_valid", 32'(ifu_valid), 32'd0);
        chk("midrst_pc", pc, 32'h8000_0000);
        chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC;
        model_cnt = '0;
        do_fetch(0, 1, 32'h0000_0073, 1'b0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Reset while an instruction is being offered
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_2222;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("offer_valid", 32'(ifu_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_offer_valid", 32'(ifu_valid), 32'd0);
        chk("rst_offer_ins", real_ins, 32'd0);
        chk("rst_offer_cnt", fetch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC;
        model_cnt = '0;
        do_fetch(0, 2, 32'h3000_0073, 1'b0, 1, 1, 1'b0, 32'd0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
